fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the RV32 core. Owns the fetch PC and issues

---
 rtl/fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_fetch_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues imem word reads and
// buffers returned words in a small FIFO handed to decode over valid/ready.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 51
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_oob,
    output logic        halted
);

    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [31:0] OOB_LIMIT = 32'(4 * MEM_WORDS);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        state_r;
    logic [31:0]   fetch_pc_r;
    logic          inflight_r;
    logic [31:0]   inflight_pc_r;
    logic          inflight_oob_r;

    logic [31:0]   fifo_pc_r    [DEPTH];
    logic [31:0]   fifo_instr_r [DEPTH];
    logic          fifo_oob_r   [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic          pop_s;
    logic [CW:0]   occ_s;
    logic [CW:0]   cap_s;
    logic          room_s;
    logic          alloc_s;
    logic          oob_s;
    logic          unused_s;

    // A head popped this cycle frees its slot, so streaming sustains one word per cycle.
    assign pop_s    = (count_r != {CW{1'b0}}) && if_ready;
    assign occ_s    = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
    assign cap_s    = (CW + 1)'(DEPTH) + {{CW{1'b0}}, pop_s};
    assign room_s   = occ_s < cap_s;
    assign alloc_s  = !rst && !redirect_valid && (state_r == ST_RUN) && !halt_req && room_s;
    assign oob_s    = fetch_pc_r >= OOB_LIMIT;
    assign unused_s = ^redirect_pc[1:0];

    assign imem_en   = alloc_s && !oob_s;
    assign imem_addr = fetch_pc_r;
    assign if_valid  = count_r != {CW{1'b0}};
    assign if_pc     = fifo_pc_r[rd_ptr_r];
    assign if_instr  = fifo_instr_r[rd_ptr_r];
    assign if_oob    = fifo_oob_r[rd_ptr_r];
    assign halted    = (state_r == ST_HALT) && !inflight_r && (count_r == {CW{1'b0}});

    // Run/halt state, fetch PC and the single in-flight request slot
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_RUN;
            fetch_pc_r     <= RESET_PC;
            inflight_r     <= 1'b0;
            inflight_pc_r  <= RESET_PC;
            inflight_oob_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN:  if (halt_req)  state_r <= ST_HALT;
                ST_HALT: if (!halt_req) state_r <= ST_RUN;
                default: state_r <= ST_RUN;
            endcase
            if (redirect_valid) begin
                fetch_pc_r <= {redirect_pc[31:2], 2'b00};
                inflight_r <= 1'b0;
            end else begin
                if (alloc_s) fetch_pc_r <= fetch_pc_r + 32'd4;
                inflight_r     <= alloc_s;
                inflight_pc_r  <= fetch_pc_r;
                inflight_oob_r <= oob_s;
            end
        end
    end

    // Instruction FIFO: the in-flight response lands one cycle after issue
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]    <= 32'h0000_0000;
                fifo_instr_r[i] <= 32'h0000_0000;
                fifo_oob_r[i]   <= 1'b0;
            end
        end else if (redirect_valid) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (inflight_r) begin
                fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
                fifo_instr_r[wr_ptr_r] <= inflight_oob_r ? NOP_INSTR : imem_rdata;
                fifo_oob_r[wr_ptr_r]   <= inflight_oob_r;
                wr_ptr_r               <= wr_ptr_r + PW'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({inflight_r, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a vector table, directed multi-cycle corner cases and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_ctrl;

    localparam int          DEPTH     = 2;
    localparam int          MEM_WORDS = 51;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] LIMIT     = 32'(4 * MEM_WORDS);
    localparam logic [31:0] NOP       = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst, redirect_valid, halt_req, if_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_en, if_valid, if_oob, halted;
    logic [31:0] imem_addr, if_pc, if_instr;

    fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_oob(if_oob), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] addr);
        return (addr >> 2) + 32'd1;
    endfunction

    // Instruction memory: one-cycle read latency, garbage when not strobed
    always @(posedge clk) imem_rdata <= imem_en ? memword(imem_addr) : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        oob;
    } entry_t;

    entry_t      mq[$];
    logic        m_inf, m_inf_oob, m_halt;
    logic [31:0] m_inf_pc, m_pc;
    logic        e_pop, e_alloc;
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] rp,
                         input logic hq, input logic rdy);
        rst = r; redirect_valid = rv; redirect_pc = rp; halt_req = hq; if_ready = rdy;
        #1;
        e_pop   = (mq.size() > 0) && if_ready;
        e_alloc = !rst && !redirect_valid && !m_halt && !halt_req &&
                  (mq.size() + int'(m_inf) < DEPTH + int'(e_pop));
    endtask

    task automatic check_model();
        chk("imem_en", 32'(imem_en), 32'(e_alloc && (m_pc < LIMIT)));
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
        chk("halted", 32'(halted), 32'(m_halt && !m_inf && mq.size() == 0));
        if (mq.size() > 0) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instr", if_instr, mq[0].instr);
            chk("if_oob", 32'(if_oob), 32'(mq[0].oob));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_inf = 1'b0; m_pc = RESET_PC; m_halt = 1'b0;
        end else begin
            if (redirect_valid) begin
                mq.delete(); m_inf = 1'b0; m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (e_pop) void'(mq.pop_front());
                if (m_inf) mq.push_back({m_inf_pc, m_inf_oob ? NOP : memword(m_inf_pc), m_inf_oob});
                m_inf = e_alloc; m_inf_pc = m_pc; m_inf_oob = (m_pc >= LIMIT);
                if (e_alloc) m_pc = m_pc + 32'd4;
            end
            m_halt = halt_req;
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic r, input logic rv, input logic [31:0] rp,
                       input logic hq, input logic rdy);
        drive(r, rv, rp, hq, rdy);
        check_model();
        advance();
    endtask

    typedef struct {
        logic        rdy;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic e_en, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.rdy = rdy; v.e_en = e_en; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    initial begin
        vec_t vt[$];
        logic hq_rand;
        logic got;

        m_inf = 1'b0; m_inf_oob = 1'b0; m_halt = 1'b0; m_inf_pc = 32'h0; m_pc = RESET_PC;

        // Reset, then reset-state checks while rst is still asserted
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); advance();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_en", 32'(imem_en), 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        advance();

        // Streaming from reset, a 10-cycle stall, then resume
        vt.push_back(mk(1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'd1));
        vt.push_back(mk(1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'd2));
        vt.push_back(mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'd3));
        for (int i = 0; i < 10; i++) vt.push_back(mk(1'b0, 1'b0, 32'h14, 1'b1, 32'hC, 32'd4));
        vt.push_back(mk(1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'd4));
        vt.push_back(mk(1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 32'd5));
        vt.push_back(mk(1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'd6));
        for (int i = 0; i < vt.size(); i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, vt[i].rdy);
            chk("tbl_en", 32'(imem_en), 32'(vt[i].e_en));
            chk("tbl_addr", imem_addr, vt[i].e_addr);
            chk("tbl_valid", 32'(if_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk("tbl_pc", if_pc, vt[i].e_pc);
                chk("tbl_instr", if_instr, vt[i].e_instr);
            end
            advance();
        end

        // Redirect to an unaligned target with the FIFO full
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0022, 1'b0, 1'b1);
        chk("redir_en", 32'(imem_en), 32'h0); check_model(); advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("redir_flush", 32'(if_valid), 32'h0);
        chk("redir_en1", 32'(imem_en), 32'h1);
        chk("redir_addr", imem_addr, 32'h20); check_model(); advance();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("redir_pc", if_pc, 32'h20);
        chk("redir_instr", if_instr, 32'd9); check_model(); advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("redir_next", if_pc, 32'h24); check_model(); advance();

        // Run off the end of the memory
        cyc(1'b0, 1'b1, 32'h0000_00C8, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("last_en", 32'(imem_en), 32'h1); check_model(); advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("oob_en", 32'(imem_en), 32'h0);
        chk("oob_addr", imem_addr, 32'hCC); check_model(); advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("last_oob", 32'(if_oob), 32'h0);
        chk("last_pc", if_pc, 32'hC8); check_model(); advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("oob_pc", if_pc, 32'hCC);
        chk("oob_instr", if_instr, NOP);
        chk("oob_flag", 32'(if_oob), 32'h1); check_model(); advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("oob_later", 32'(if_oob), 32'h1); check_model(); advance();

        // Halt mid-stream, drain, then resume at the next sequential pc
        cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("halt_en", 32'(imem_en), 32'h0); check_model(); advance();
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            check_model();
            got = halted;
            advance();
        end
        chk("halt_reached", 32'(got), 32'h1);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check_model();
            if (imem_en) begin
                got = 1'b1;
                chk("resume_addr", imem_addr, 32'h50);
            end
            advance();
        end
        chk("resume_seen", 32'(got), 32'h1);

        // Reset with data buffered and a request in flight
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("mrst_valid", 32'(if_valid), 32'h0);
        chk("mrst_addr", imem_addr, RESET_PC);
        chk("mrst_en", 32'(imem_en), 32'h1); check_model(); advance();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("mrst_pc", if_pc, RESET_PC);
        chk("mrst_instr", if_instr, 32'd1); check_model(); advance();

        // Randomized traffic against the reference model
        hq_rand = 1'b0;
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rp;
            if ($urandom_range(0, 29) == 0) hq_rand = !hq_rand;
            rp = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, rp,
                hq_rand, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
